vector_mem_responder: RTL

//  Responder end of the vector memory interface driven by vector_top: accepts read/write requests,

---
 rtl/vmem_pkg.sv | 40 ++++
 rtl/vmem_line_ram.sv | 39 +++
 rtl/vector_mem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// Shared types and byte-lane helpers for the vector memory responder.
// A line is 32 bytes; element accesses are 1, 2 or 4 bytes wide.
package vmem_pkg;

    localparam int LINE_BYTES = 32;

    typedef enum logic [1:0] {
        SEW8    = 2'b00,
        SEW16   = 2'b01,
        SEW32   = 2'b10,
        SEW_RSV = 2'b11
    } sew_e;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    function automatic logic [2:0] sew_bytes(input sew_e sew);
        case (sew)
            SEW8:    return 3'd1;
            SEW16:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte offset inside the line, truncated down to element alignment.
    function automatic logic [4:0] elem_offset(input sew_e sew, input logic [4:0] offset);
        logic [4:0] align_mask;
        align_mask = ~({2'b00, sew_bytes(sew)} - 5'd1);
        return offset & align_mask;
    endfunction

    function automatic logic [LINE_BYTES-1:0] elem_be(input sew_e sew, input logic [4:0] offset);
        logic [LINE_BYTES-1:0] lanes;
        lanes = (32'd1 << sew_bytes(sew)) - 32'd1;
        return lanes << elem_offset(sew, offset);
    endfunction

endpackage

// File: rtl/vmem_line_ram.sv
// Single-port DEPTH x 256-bit line RAM with byte enables and a registered read port.
// The output register only updates on a read, so it holds the last line read.
module vmem_line_ram
    import vmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    we,
    input  logic [LINE_BYTES-1:0]   be,
    input  logic [AW-1:0]           addr,
    input  logic [LINE_BYTES*8-1:0] wdata,
    output logic [LINE_BYTES*8-1:0] rdata
);

    logic [LINE_BYTES*8-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/vector_mem_responder.sv
// Responder for the vector memory interface: line RAM with fixed read latency,
// element merge/extract, op_done counter and a sticky rd+wr protocol error flag.
module vector_mem_responder
    import vmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_valid_rd,
    input  logic         mem_valid_wr,
    input  logic         mem_unit,
    input  logic [1:0]   mem_sew,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_data_wr,
    input  logic         mem_op_done,
    output logic         mem_valid_o,
    output logic [255:0] mem_data_o,
    output logic         mem_ready,
    output logic [15:0]  op_count,
    output logic         protocol_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RD_LAT + 1);

    state_e          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            ready_en;
    logic            accept, wr_acc, rd_acc, rd_fire;
    sew_e            sew_in;
    logic [4:0]      off_in;
    logic [31:0]     be;
    logic [255:0]    wline, ram_q;
    logic            rd_unit;
    sew_e            rd_sew;
    logic [4:0]      rd_off;
    logic            unused_addr;

    function automatic logic [255:0] extract(input logic [255:0] line, input logic unit,
                                             input sew_e sew, input logic [4:0] off);
        logic [255:0] sh;
        sh = line >> {off, 3'b000};
        if (unit) return line;
        case (sew)
            SEW8:    return {248'd0, sh[7:0]};
            SEW16:   return {240'd0, sh[15:0]};
            default: return {224'd0, sh[31:0]};
        endcase
    endfunction

    assign unused_addr = ^mem_address[31:5+AW];

    assign mem_ready = ready_en && (state == IDLE);
    assign accept    = (mem_valid_rd || mem_valid_wr) && mem_ready;
    assign wr_acc    = accept && mem_valid_wr;
    assign rd_acc    = accept && mem_valid_rd && !mem_valid_wr;
    assign rd_fire   = (state == RD_WAIT) && (cnt == CW'(1));

    assign sew_in = sew_e'(mem_sew);
    assign off_in = elem_offset(sew_in, mem_address[4:0]);
    assign be     = mem_unit ? '1 : elem_be(sew_in, mem_address[4:0]);
    assign wline  = mem_unit ? mem_data_wr : (mem_data_wr << {off_in, 3'b000});

    vmem_line_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (wr_acc || rd_acc),
        .we    (wr_acc),
        .be    (be),
        .addr  (mem_address[5 +: AW]),
        .wdata (wline),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ready_en     <= 1'b0;
            op_count     <= '0;
            protocol_err <= 1'b0;
            rd_unit      <= 1'b0;
            rd_sew       <= SEW8;
            rd_off       <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ready_en <= 1'b1;
            if (mem_op_done) op_count <= op_count + 16'd1;
            if (accept && mem_valid_rd && mem_valid_wr) protocol_err <= 1'b1;
            if (rd_acc) begin
                rd_unit <= mem_unit;
                rd_sew  <= sew_in;
                rd_off  <= off_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (rd_acc && (RD_LAT > 1)) begin
                    state_nx = RD_WAIT;
                    cnt_nx   = CW'(RD_LAT - 1);
                end
            end
            RD_WAIT: begin
                cnt_nx = cnt - CW'(1);
                if (rd_fire) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle latency: the RAM output register is the response register.
    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) mem_valid_o <= 1'b0;
            else      mem_valid_o <= rd_acc;
        end
        assign mem_data_o = extract(ram_q, rd_unit, rd_sew, rd_off);
    end else begin : g_latn
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mem_valid_o <= 1'b0;
                mem_data_o  <= '0;
            end else begin
                mem_valid_o <= rd_fire;
                if (rd_fire) mem_data_o <= extract(ram_q, rd_unit, rd_sew, rd_off);
            end
        end
    end

endmodule
